// File: rtl/axi4lite_pkg.sv
// axi4lite_pkg: shared AXI4-Lite response codes, default widths and strobe width helper
package axi4lite_pkg;
  typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} resp_e;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;
  function automatic int strb_width(int dw);
    return dw / 8;
  endfunction
endpackage

// File: rtl/axi4lite_if.sv
// axi4lite_if: AXI4-Lite bus signal set with master and slave views
interface axi4lite_if
  import axi4lite_pkg::*;
#(parameter int ADDR_WIDTH = AXI_ADDR_WIDTH, parameter int DATA_WIDTH = AXI_DATA_WIDTH);
  logic                              AW_VALID, AW_READY;
  logic [ADDR_WIDTH-1:0]             AW_ADDR;
  logic [2:0]                        AW_PROT;
  logic                              W_VALID, W_READY;
  logic [DATA_WIDTH-1:0]             W_DATA;
  logic [strb_width(DATA_WIDTH)-1:0] W_STRB;
  logic                              B_VALID, B_READY;
  logic [1:0]                        B_RESP;
  logic                              AR_VALID, AR_READY;
  logic [ADDR_WIDTH-1:0]             AR_ADDR;
  logic [2:0]                        AR_PROT;
  logic                              R_VALID, R_READY;
  logic [DATA_WIDTH-1:0]             R_DATA;
  logic [1:0]                        R_RESP;
  modport master (
    output AW_VALID, AW_ADDR, AW_PROT, W_VALID, W_DATA, W_STRB, B_READY, AR_VALID, AR_ADDR, AR_PROT, R_READY,
    input  AW_READY, W_READY, B_VALID, B_RESP, AR_READY, R_VALID, R_DATA, R_RESP
  );
  modport slave (
    input  AW_VALID, AW_ADDR, AW_PROT, W_VALID, W_DATA, W_STRB, B_READY, AR_VALID, AR_ADDR, AR_PROT, R_READY,
    output AW_READY, W_READY, B_VALID, B_RESP, AR_READY, R_VALID, R_DATA, R_RESP
  );
endinterface

// File: rtl/axi4lite_addr_decode.sv
// axi4lite_addr_decode: byte address to register index, flagging any address bit above the index field
module axi4lite_addr_decode
  import axi4lite_pkg::*;
#(
  parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH = AXI_DATA_WIDTH,
  parameter int NUM_REGS   = 16
) (
  input  logic [ADDR_WIDTH-1:0]       addr,
  output logic [$clog2(NUM_REGS)-1:0] index,
  output logic                        err
);
  localparam int OW = $clog2(strb_width(DATA_WIDTH));
  localparam int IW = $clog2(NUM_REGS);
  assign index = addr[OW +: IW];
  assign err   = |(addr >> (OW + IW));
endmodule

// File: rtl/axi4lite_slave_regs.sv
// axi4lite_slave_regs: AXI4-Lite register bank with byte strobes, read-only ID at register 0
module axi4lite_slave_regs
  import axi4lite_pkg::*;
#(
  parameter int          ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int          DATA_WIDTH = AXI_DATA_WIDTH,
  parameter int          NUM_REGS   = 16,
  parameter logic [31:0] ID_VALUE   = 32'hA110_0001
) (
  input  logic                           A_CLK,
  input  logic                           A_RST,
  axi4lite_if.slave                      s,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_q,
  output logic [NUM_REGS-1:0]            wr_pulse
);
  localparam int IW = $clog2(NUM_REGS);
  localparam int SW = strb_width(DATA_WIDTH);
  typedef enum logic {W_IDLE, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;
  wstate_e               ws, ws_n;
  rstate_e               rs, rs_n;
  logic                  aw_held, w_held, aw_err_q, aw_err_d, ar_err;
  logic [IW-1:0]         aw_idx_q, aw_idx_d, ar_idx, idx;
  logic [DATA_WIDTH-1:0] w_data_q, wdata, r_data;
  logic [SW-1:0]         w_strb_q, wstrb;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [1:0]            b_resp, r_resp;
  logic                  aw_fire, w_fire, ar_fire, commit, err, wr_ok;
  logic                  unused_prot;
  axi4lite_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS)) u_aw_dec (
    .addr(s.AW_ADDR), .index(aw_idx_d), .err(aw_err_d)
  );
  axi4lite_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS)) u_ar_dec (
    .addr(s.AR_ADDR), .index(ar_idx), .err(ar_err)
  );
  assign unused_prot = ^{s.AW_PROT, s.AR_PROT};
  assign s.AW_READY = !aw_held && ws == W_IDLE && !A_RST;
  assign s.W_READY  = !w_held && ws == W_IDLE && !A_RST;
  assign s.AR_READY = rs == R_IDLE && !A_RST;
  assign s.B_VALID  = ws == W_RESP;
  assign s.B_RESP   = b_resp;
  assign s.R_VALID  = rs == R_DATA;
  assign s.R_DATA   = r_data;
  assign s.R_RESP   = r_resp;
  // Commit uses the held beat if present, otherwise the one handshaking this cycle
  always_comb begin
    aw_fire = s.AW_VALID && s.AW_READY;
    w_fire  = s.W_VALID && s.W_READY;
    ar_fire = s.AR_VALID && s.AR_READY;
    idx     = aw_held ? aw_idx_q : aw_idx_d;
    err     = aw_held ? aw_err_q : aw_err_d;
    wdata   = w_held ? w_data_q : s.W_DATA;
    wstrb   = w_held ? w_strb_q : s.W_STRB;
    commit  = ws == W_IDLE && (aw_held || aw_fire) && (w_held || w_fire);
    wr_ok   = commit && !err && idx != '0;
    ws_n    = ws == W_IDLE ? (commit ? W_RESP : W_IDLE) : (s.B_READY ? W_IDLE : W_RESP);
    rs_n    = rs == R_IDLE ? (ar_fire ? R_DATA : R_IDLE) : (s.R_READY ? R_IDLE : R_DATA);
  end
  always_ff @(posedge A_CLK or posedge A_RST)
    if (A_RST) begin
      ws <= W_IDLE;
      rs <= R_IDLE;
    end else begin
      ws <= ws_n;
      rs <= rs_n;
    end
  always_ff @(posedge A_CLK or posedge A_RST)
    if (A_RST) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx_q <= '0;
      aw_err_q <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
      b_resp   <= OKAY;
      wr_pulse <= '0;
    end else begin
      aw_held  <= commit ? 1'b0 : aw_held || aw_fire;
      w_held   <= commit ? 1'b0 : w_held || w_fire;
      if (aw_fire) begin
        aw_idx_q <= aw_idx_d;
        aw_err_q <= aw_err_d;
      end
      if (w_fire) begin
        w_data_q <= s.W_DATA;
        w_strb_q <= s.W_STRB;
      end
      wr_pulse <= wr_ok ? NUM_REGS'(1) << idx : '0;
      if (commit) b_resp <= wr_ok ? OKAY : SLVERR;
    end
  always_ff @(posedge A_CLK or posedge A_RST)
    if (A_RST) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      for (int b = 0; b < SW; b++) if (wstrb[b]) regs[idx][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  // Reads sample the array before this edge's write lands
  always_ff @(posedge A_CLK or posedge A_RST)
    if (A_RST) begin
      r_data <= '0;
      r_resp <= OKAY;
    end else if (ar_fire) begin
      r_data <= ar_err ? '0 : ar_idx == '0 ? DATA_WIDTH'(ID_VALUE) : regs[ar_idx];
      r_resp <= ar_err ? SLVERR : OKAY;
    end
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_q
    assign regs_q[i*DATA_WIDTH +: DATA_WIDTH] = i == 0 ? DATA_WIDTH'(ID_VALUE) : regs[i];
  end
endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// tb_axi4lite_slave_regs: directed vectors for the AXI4-Lite register bank
module tb_axi4lite_slave_regs;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [511:0] regs_q;
  logic [15:0]  wr_pulse;
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [1:0]   resp;
  logic [31:0]  data;
  axi4lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  axi4lite_slave_regs dut (.A_CLK(clk), .A_RST(rst), .s(bus), .regs_q(regs_q), .wr_pulse(wr_pulse));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] strb, output logic [1:0] r);
    logic aw_pend, w_pend, aw_go, w_go;
    aw_pend = 1'b1;
    w_pend = 1'b1;
    bus.AW_ADDR = addr;
    bus.W_DATA = d;
    bus.W_STRB = strb;
    bus.AW_VALID = 1'b1;
    bus.W_VALID = 1'b1;
    for (int n = 0; n < 10 && (aw_pend || w_pend); n++) begin
      aw_go = aw_pend && bus.AW_READY;
      w_go = w_pend && bus.W_READY;
      tick();
      if (aw_go) begin aw_pend = 1'b0; bus.AW_VALID = 1'b0; end
      if (w_go) begin w_pend = 1'b0; bus.W_VALID = 1'b0; end
    end
    bus.AW_VALID = 1'b0;
    bus.W_VALID = 1'b0;
    check("wr_handshake_timeout", {aw_pend, w_pend}, 0);
    for (int n = 0; n < 10 && !bus.B_VALID; n++) tick();
    check("wr_bvalid_timeout", bus.B_VALID, 1);
    r = bus.B_RESP;
    bus.B_READY = 1'b1;
    tick();
    bus.B_READY = 1'b0;
  endtask
  task automatic rd(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
    logic go;
    go = 1'b0;
    bus.AR_ADDR = addr;
    bus.AR_VALID = 1'b1;
    for (int n = 0; n < 10 && !go; n++) begin
      go = bus.AR_READY;
      tick();
    end
    bus.AR_VALID = 1'b0;
    check("rd_handshake_timeout", go, 1);
    for (int n = 0; n < 10 && !bus.R_VALID; n++) tick();
    check("rd_rvalid_timeout", bus.R_VALID, 1);
    d = bus.R_DATA;
    r = bus.R_RESP;
    bus.R_READY = 1'b1;
    tick();
    bus.R_READY = 1'b0;
  endtask
  initial begin
    {bus.AW_VALID, bus.W_VALID, bus.B_READY, bus.AR_VALID, bus.R_READY} = '0;
    bus.AW_ADDR = '0; bus.AR_ADDR = '0; bus.AW_PROT = '0; bus.AR_PROT = '0;
    bus.W_DATA = '0; bus.W_STRB = '0;
    tick();
    check("rst_ready", {bus.AW_READY, bus.W_READY, bus.AR_READY}, 0);
    check("rst_valid", {bus.B_VALID, bus.R_VALID}, 0);
    check("rst_resp_rdata", {bus.B_RESP, bus.R_RESP, bus.R_DATA}, 0);
    check("rst_regs", |regs_q[511:32], 0);
    check("rst_id", regs_q[31:0], 32'hA110_0001);
    check("rst_pulse", wr_pulse, 0);
    tick();
    rst = 1'b0;
    tick();
    check("idle_ready", {bus.AW_READY, bus.W_READY, bus.AR_READY}, 3'b111);
    // AW and W together: one-cycle latency
    bus.AW_ADDR = 32'h04; bus.W_DATA = 32'hDEADBEEF; bus.W_STRB = 4'hF;
    bus.AW_VALID = 1'b1; bus.W_VALID = 1'b1;
    tick();
    bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0;
    check("t1_bvalid", bus.B_VALID, 1);
    check("t1_bresp", bus.B_RESP, 2'b00);
    check("t1_reg1", regs_q[63:32], 32'hDEADBEEF);
    check("t1_pulse", wr_pulse, 16'h0002);
    check("t1_ready_busy", {bus.AW_READY, bus.W_READY}, 0);
    bus.B_READY = 1'b1;
    tick();
    bus.B_READY = 1'b0;
    check("t1_bclear", bus.B_VALID, 0);
    check("t1_pulse_clear", wr_pulse, 0);
    // W three cycles ahead of AW, partial strobes
    wr(32'h08, 32'hFFFFFFFF, 4'hF, resp);
    check("t2_pre_resp", resp, 2'b00);
    bus.W_DATA = 32'h11223344; bus.W_STRB = 4'b0101; bus.W_VALID = 1'b1;
    tick();
    bus.W_VALID = 1'b0;
    check("t2_w_held", {bus.W_READY, bus.AW_READY, bus.B_VALID}, 3'b010);
    tick();
    tick();
    check("t2_no_commit", {bus.B_VALID, regs_q[95:64]}, {1'b0, 32'hFFFFFFFF});
    bus.AW_ADDR = 32'h08; bus.AW_VALID = 1'b1;
    tick();
    bus.AW_VALID = 1'b0;
    check("t2_bvalid", {bus.B_VALID, bus.B_RESP}, 3'b100);
    check("t2_reg2", regs_q[95:64], 32'hFF22FF44);
    check("t2_pulse", wr_pulse, 16'h0004);
    bus.B_READY = 1'b1;
    tick();
    bus.B_READY = 1'b0;
    // Decode errors and the read-only ID register
    wr(32'h00, 32'h12345678, 4'hF, resp);
    check("t3_wr_id_resp", resp, 2'b10);
    wr(32'h40, 32'h12345678, 4'hF, resp);
    check("t3_wr_oob_resp", resp, 2'b10);
    check("t3_regs_kept", {regs_q[95:32]}, {32'hFF22FF44, 32'hDEADBEEF});
    check("t3_id_kept", regs_q[31:0], 32'hA110_0001);
    rd(32'h00, data, resp);
    check("t3_rd_id", {resp, data}, {2'b00, 32'hA110_0001});
    rd(32'h40, data, resp);
    check("t3_rd_oob", {resp, data}, {2'b10, 32'h0});
    rd(32'h0B, data, resp);
    check("t3_rd_offset", {resp, data}, {2'b00, 32'hFF22FF44});
    // Zero strobe still pulses; SLVERR write issues no pulse
    bus.AW_ADDR = 32'h08; bus.W_DATA = 32'h0; bus.W_STRB = 4'h0;
    bus.AW_VALID = 1'b1; bus.W_VALID = 1'b1;
    tick();
    bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0;
    check("t4_strb0", {bus.B_RESP, wr_pulse, regs_q[95:64]}, {2'b00, 16'h0004, 32'hFF22FF44});
    bus.B_READY = 1'b1;
    tick();
    bus.B_READY = 1'b0;
    // Response held under back-pressure
    bus.AW_ADDR = 32'h00; bus.W_DATA = 32'h1; bus.W_STRB = 4'hF;
    bus.AW_VALID = 1'b1; bus.W_VALID = 1'b1;
    tick();
    check("t5_err_pulse", wr_pulse, 0);
    for (int i = 0; i < 5; i++) begin
      check("t5_hold", {bus.B_VALID, bus.B_RESP, bus.AW_READY, bus.W_READY}, 5'b11000);
      tick();
    end
    bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0;
    bus.B_READY = 1'b1;
    tick();
    bus.B_READY = 1'b0;
    check("t5_release", {bus.B_VALID, bus.AW_READY, bus.W_READY}, 3'b011);
    // Read and write of the same register at one edge
    wr(32'h04, 32'h1, 4'hF, resp);
    bus.AR_ADDR = 32'h04; bus.AW_ADDR = 32'h04; bus.W_DATA = 32'h5; bus.W_STRB = 4'hF;
    bus.AR_VALID = 1'b1; bus.AW_VALID = 1'b1; bus.W_VALID = 1'b1;
    tick();
    bus.AR_VALID = 1'b0; bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0;
    check("t6_rd_old", {bus.R_VALID, bus.R_DATA}, {1'b1, 32'h1});
    check("t6_reg1_new", regs_q[63:32], 32'h5);
    bus.R_READY = 1'b1; bus.B_READY = 1'b1;
    tick();
    bus.R_READY = 1'b0; bus.B_READY = 1'b0;
    rd(32'h04, data, resp);
    check("t6_rd_new", {resp, data}, {2'b00, 32'h5});
    // Reset mid-transaction
    bus.AR_ADDR = 32'h04; bus.AR_VALID = 1'b1;
    tick();
    bus.AR_VALID = 1'b0;
    bus.AW_ADDR = 32'h0C; bus.AW_VALID = 1'b1;
    tick();
    bus.AW_VALID = 1'b0;
    check("t7_pre", {bus.R_VALID, bus.AW_READY}, 2'b10);
    rst = 1'b1;
    #1;
    check("t7_rst_valid", {bus.R_VALID, bus.B_VALID, bus.R_DATA, bus.R_RESP}, 0);
    check("t7_rst_ready", {bus.AW_READY, bus.W_READY, bus.AR_READY}, 0);
    check("t7_rst_regs", {|regs_q[511:32], wr_pulse}, 0);
    tick();
    rst = 1'b0;
    tick();
    bus.W_DATA = 32'hCAFEF00D; bus.W_STRB = 4'hF; bus.W_VALID = 1'b1;
    tick();
    bus.W_VALID = 1'b0;
    check("t7_aw_dropped", {bus.B_VALID, bus.AW_READY}, 2'b01);
    bus.AW_ADDR = 32'h0C; bus.AW_VALID = 1'b1;
    tick();
    bus.AW_VALID = 1'b0;
    check("t7_write", {bus.B_VALID, bus.B_RESP, wr_pulse}, {3'b100, 16'h0008});
    check("t7_reg3", regs_q[127:96], 32'hCAFEF00D);
    bus.B_READY = 1'b1;
    tick();
    bus.B_READY = 1'b0;
    check("t7_done", bus.B_VALID, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
